sd_block_responder: RTL and testbench

Synthesizable SD-card block-device responder. It sits on the target side of the byte-level SD/SPI host request interface (`spi_rst`, `spi_r_block`, `spi_r_byte`, `spi_w_block`, `spi_w_byte`, `spi_busy`) and answers the same handshake the autotest controllers drive. Block data comes from an on-chip RAM instead of a physical card. Its purpose is card-less regression and FPGA self-test of the autotest FSMs.

---
 rtl/sd_block_responder_pkg.sv | 27 ++
 rtl/memory_module.sv | 26 ++
 rtl/sd_block_responder_storage.sv | 31 +++
 rtl/sd_block_responder.sv | 246 ++++++++++++++++++++++++
 tb/tb_sd_block_responder.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_block_responder_pkg.sv
// Shared definitions for the SD block-device responder: block geometry,
// default base address and the responder state encoding.
package configuration;

  localparam int unsigned SD_BLOCK_BYTES = 512;
  localparam logic [31:0] SD_BASE_ADDR   = 32'h0010_0000;
  localparam int unsigned SD_PTR_W       = 10;

  typedef enum logic [3:0] {
    StIdle,
    StInit,
    StRdLoad,
    StRdReady,
    StRdByte,
    StWrLoad,
    StWrReady,
    StWrByte,
    StWrCommit,
    StErrHold
  } sd_resp_state_t;

  // Byte pointer advance, saturating at all-ones.
  function automatic logic [SD_PTR_W-1:0] sd_ptr_inc(input logic [SD_PTR_W-1:0] ptr);
    return (ptr == {SD_PTR_W{1'b1}}) ? ptr : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/memory_module.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module memory_module #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sd_block_responder_storage.sv
// Block storage for the responder: NUM_BLOCKS x 512 bytes, addressed as {block, byte}.
module sd_block_responder_storage
  import configuration::*;
#(
  parameter int unsigned NUM_BLOCKS = 4
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [$clog2(NUM_BLOCKS)-1:0] wblk_i,
  input  logic [8:0]                    wptr_i,
  input  logic [7:0]                    wdata_i,
  input  logic [$clog2(NUM_BLOCKS)-1:0] rblk_i,
  input  logic [8:0]                    rptr_i,
  output logic [7:0]                    rdata_o
);

  localparam int unsigned AddrW = $clog2(NUM_BLOCKS) + 9;

  memory_module #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (AddrW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (we_i),
    .waddr_i ({wblk_i, wptr_i}),
    .wdata_i (wdata_i),
    .raddr_i ({rblk_i, rptr_i}),
    .rdata_o (rdata_o)
  );

endmodule

// File: rtl/sd_block_responder.sv
// SD-card block-device responder backed by on-chip RAM; answers the byte-level
// SD host request handshake with configurable busy latencies.
module sd_block_responder
  import configuration::*;
#(
  parameter logic [31:0] BASE_ADDR     = SD_BASE_ADDR,
  parameter int unsigned NUM_BLOCKS    = 4,
  parameter int unsigned INIT_CYCLES   = 16,
  parameter int unsigned BLOCK_LATENCY = 8,
  parameter int unsigned BYTE_LATENCY  = 2,
  parameter int unsigned COMMIT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_rst,
  input  logic        spi_r_block,
  input  logic        spi_r_byte,
  input  logic        spi_r_multi_block,
  input  logic        spi_w_block,
  input  logic        spi_w_byte,
  input  logic [31:0] spi_block_addr,
  input  logic [7:0]  spi_data_in,
  output logic        spi_busy,
  output logic [7:0]  spi_data_out,
  output logic        spi_err,
  output logic        spi_crc_err
);

  localparam int unsigned BlkW     = $clog2(NUM_BLOCKS);
  localparam logic [15:0] InitLd   = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] BlkLd    = 16'(BLOCK_LATENCY - 1);
  localparam logic [15:0] ByteLd   = 16'(BYTE_LATENCY - 1);
  localparam logic [15:0] CommitLd = 16'(COMMIT_CYCLES - 1);
  localparam logic [SD_PTR_W-1:0] LastPtr = SD_PTR_W'(SD_BLOCK_BYTES - 1);

  sd_resp_state_t      state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [SD_PTR_W-1:0] ptr_q, ptr_d;
  logic [BlkW-1:0]     blk_q, blk_d;
  logic                busy_q, busy_d;
  logic [7:0]          data_q, data_d;
  logic                err_q, err_d;
  logic                init_done_q, init_done_d;
  logic                gap_q, gap_d;

  logic [31:0] addr_off;
  logic        addr_ok;
  logic        any_req;
  logic        phase_done;
  logic        mem_we;
  logic        go_err;
  logic [7:0]  rdata;

  // Unsigned offset makes addresses below the base wrap to huge values.
  assign addr_off   = spi_block_addr - BASE_ADDR;
  assign addr_ok    = addr_off < 32'(NUM_BLOCKS);
  assign any_req    = spi_rst | spi_r_block | spi_r_byte | spi_r_multi_block |
                      spi_w_block | spi_w_byte;
  assign phase_done = (cnt_q == 16'd0);

  // The initiator's data settles one cycle after acceptance, so write on the first WR_BYTE cycle.
  assign mem_we = (state_q == StWrByte) && (cnt_q == ByteLd) && !ptr_q[SD_PTR_W-1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    blk_d       = blk_q;
    busy_d      = busy_q;
    data_d      = data_q;
    err_d       = err_q;
    init_done_d = init_done_q;
    go_err      = 1'b0;

    if (busy_q && !phase_done) begin
      cnt_d = cnt_q - 16'd1;
    end

    case (state_q)
      StIdle: begin
        if (!gap_q) begin
          if (spi_rst) begin
            state_d = StInit;
            busy_d  = 1'b1;
            cnt_d   = InitLd;
            err_d   = 1'b0;
          end else if (spi_r_multi_block || (spi_r_block && spi_w_block)) begin
            go_err = 1'b1;
          end else if (spi_r_block || spi_w_block) begin
            if (!init_done_q || !addr_ok) begin
              go_err = 1'b1;
            end else begin
              state_d = spi_r_block ? StRdLoad : StWrLoad;
              blk_d   = addr_off[BlkW-1:0];
              ptr_d   = '0;
              busy_d  = 1'b1;
              cnt_d   = BlkLd;
            end
          end
        end
      end

      StInit: begin
        if (phase_done) begin
          busy_d      = 1'b0;
          init_done_d = 1'b1;
          state_d     = StIdle;
        end
      end

      StRdLoad, StRdByte: begin
        if (phase_done) begin
          busy_d = 1'b0;
          data_d = ptr_q[SD_PTR_W-1] ? 8'hFF : rdata;
          if (spi_r_block) begin
            state_d = StRdReady;
          end else begin
            state_d = StIdle;
            ptr_d   = '0;
          end
        end
      end

      StRdReady: begin
        if (!spi_r_block) begin
          state_d = StIdle;
          ptr_d   = '0;
        end else if (spi_r_byte && !gap_q) begin
          state_d = StRdByte;
          ptr_d   = sd_ptr_inc(ptr_q);
          busy_d  = 1'b1;
          cnt_d   = ByteLd;
        end
      end

      StWrLoad, StWrCommit: begin
        if (phase_done) begin
          busy_d = 1'b0;
          if (spi_w_block) begin
            state_d = StWrReady;
          end else begin
            state_d = StIdle;
            ptr_d   = '0;
          end
        end
      end

      StWrReady: begin
        if (!spi_w_block) begin
          state_d = StIdle;
          ptr_d   = '0;
        end else if (spi_w_byte && !gap_q) begin
          state_d = StWrByte;
          busy_d  = 1'b1;
          cnt_d   = ByteLd;
        end
      end

      StWrByte: begin
        if (phase_done) begin
          ptr_d = sd_ptr_inc(ptr_q);
          if (ptr_q == LastPtr) begin
            // Commit extends the same busy window without a low cycle.
            state_d = StWrCommit;
            cnt_d   = CommitLd;
          end else begin
            busy_d = 1'b0;
            if (spi_w_block) begin
              state_d = StWrReady;
            end else begin
              state_d = StIdle;
              ptr_d   = '0;
            end
          end
        end
      end

      StErrHold: begin
        if (busy_q) begin
          busy_d = 1'b0;
        end else if (!any_req) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    if (go_err) begin
      state_d = StErrHold;
      busy_d  = 1'b1;
      cnt_d   = 16'd0;
      err_d   = 1'b1;
      data_d  = 8'hFF;
    end
  end

  assign gap_d = busy_q & ~busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 16'd0;
      ptr_q       <= '0;
      blk_q       <= '0;
      busy_q      <= 1'b0;
      data_q      <= 8'hFF;
      err_q       <= 1'b0;
      init_done_q <= 1'b0;
      gap_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      blk_q       <= blk_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
      err_q       <= err_d;
      init_done_q <= init_done_d;
      gap_q       <= gap_d;
    end
  end

  // Read address follows next-state so the fetched byte is ready at any phase end.
  sd_block_responder_storage #(
    .NUM_BLOCKS (NUM_BLOCKS)
  ) u_storage (
    .clk_i   (clk),
    .we_i    (mem_we),
    .wblk_i  (blk_q),
    .wptr_i  (ptr_q[8:0]),
    .wdata_i (spi_data_in),
    .rblk_i  (blk_d),
    .rptr_i  (ptr_d[8:0]),
    .rdata_o (rdata)
  );

  assign spi_busy     = busy_q;
  assign spi_data_out = data_q;
  assign spi_err      = err_q;
  assign spi_crc_err  = 1'b0;

endmodule

// File: tb/tb_sd_block_responder.sv
// Self-checking bench for sd_block_responder against a byte-array reference model.
module tb_sd_block_responder;

  localparam logic [31:0] Base   = 32'h0010_0000;
  localparam int          Nb     = 4;
  localparam int          Init   = 16;
  localparam int          BlkLat = 8;
  localparam int          ByteLat = 2;
  localparam int          Commit = 32;

  logic        clk, rst;
  logic        spi_rst, spi_r_block, spi_r_byte, spi_r_multi_block, spi_w_block, spi_w_byte;
  logic [31:0] spi_block_addr;
  logic [7:0]  spi_data_in;
  logic        spi_busy, spi_err, spi_crc_err;
  logic [7:0]  spi_data_out;

  sd_block_responder #(
    .BASE_ADDR     (Base),
    .NUM_BLOCKS    (Nb),
    .INIT_CYCLES   (Init),
    .BLOCK_LATENCY (BlkLat),
    .BYTE_LATENCY  (ByteLat),
    .COMMIT_CYCLES (Commit)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .spi_rst           (spi_rst),
    .spi_r_block       (spi_r_block),
    .spi_r_byte        (spi_r_byte),
    .spi_r_multi_block (spi_r_multi_block),
    .spi_w_block       (spi_w_block),
    .spi_w_byte        (spi_w_byte),
    .spi_block_addr    (spi_block_addr),
    .spi_data_in       (spi_data_in),
    .spi_busy          (spi_busy),
    .spi_data_out      (spi_data_out),
    .spi_err           (spi_err),
    .spi_crc_err       (spi_crc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [Nb*512];
  bit         ref_vld [Nb*512];
  bit         ref_init;
  bit         ref_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit addr_valid(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - Base;
    return off < 32'(Nb);
  endfunction

  task automatic drop_all();
    spi_rst = 0; spi_r_block = 0; spi_r_byte = 0; spi_r_multi_block = 0;
    spi_w_block = 0; spi_w_byte = 0;
  endtask

  // Waits for busy to rise, drops pulse-style requests, returns the busy length.
  task automatic phase(output int len);
    int t;
    len = 0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!spi_busy && t < 64);
    if (!spi_busy) begin
      check("busy_rise_timeout", 32'(spi_busy), 32'd1);
      return;
    end
    spi_r_byte = 0; spi_w_byte = 0; spi_rst = 0;
    while (spi_busy && len < 4000) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic count_busy(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (spi_busy) c++;
    end
  endtask

  task automatic expect_err(input int len, input string tag);
    check({tag, "_err_len"}, 32'(len), 32'd1);
    check({tag, "_err_flag"}, 32'(spi_err), 32'd1);
    check({tag, "_err_data"}, 32'(spi_data_out), 32'hFF);
    ref_err = 1;
    drop_all();
    idle(3);
  endtask

  task automatic do_init();
    int len;
    spi_rst = 1;
    phase(len);
    check("init_len", 32'(len), 32'(Init));
    check("init_err", 32'(spi_err), 32'd0);
    ref_init = 1;
    ref_err  = 0;
    idle(2);
  endtask

  task automatic open_session(input logic [31:0] addr, input bit rd, output bit ok);
    int len;
    spi_block_addr = addr;
    if (rd) spi_r_block = 1;
    else    spi_w_block = 1;
    phase(len);
    if (!ref_init || !addr_valid(addr)) begin
      expect_err(len, rd ? "rd_open" : "wr_open");
      ok = 0;
    end else begin
      check(rd ? "rd_open_len" : "wr_open_len", 32'(len), 32'(BlkLat));
      ok = 1;
    end
  endtask

  task automatic write_block(input logic [31:0] addr, input int n, input bit rnd);
    bit ok;
    int len, blk;
    logic [7:0] d;
    open_session(addr, 0, ok);
    if (!ok) return;
    blk = int'(addr - Base);
    for (int k = 0; k < n; k++) begin
      d = rnd ? 8'($urandom) : 8'(k);
      spi_data_in = d;
      spi_w_byte  = 1;
      phase(len);
      check("wr_byte_len", 32'(len), (k == 511) ? 32'(ByteLat + Commit) : 32'(ByteLat));
      if (k < 512) begin
        ref_mem[blk*512 + k] = d;
        ref_vld[blk*512 + k] = 1;
      end
    end
    spi_w_block = 0;
    idle(3);
    check("wr_err_flag", 32'(spi_err), 32'(ref_err));
  endtask

  task automatic read_block(input logic [31:0] addr, input int n);
    bit ok;
    int len, blk;
    open_session(addr, 1, ok);
    if (!ok) return;
    blk = int'(addr - Base);
    if (ref_vld[blk*512]) check("rd_byte0", 32'(spi_data_out), 32'(ref_mem[blk*512]));
    for (int k = 1; k < n; k++) begin
      spi_r_byte = 1;
      phase(len);
      check("rd_byte_len", 32'(len), 32'(ByteLat));
      if (k >= 512) check("rd_past_end", 32'(spi_data_out), 32'hFF);
      else if (ref_vld[blk*512 + k])
        check("rd_byte", 32'(spi_data_out), 32'(ref_mem[blk*512 + k]));
    end
    spi_r_block = 0;
    idle(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len, c, t;
    bit ok;
    logic [31:0] a;

    for (int i = 0; i < Nb*512; i++) begin
      ref_mem[i] = 8'h00;
      ref_vld[i] = 0;
    end
    ref_init = 0;
    ref_err  = 0;
    drop_all();
    spi_block_addr = Base;
    spi_data_in    = 8'h00;
    rst = 1;
    idle(3);
    check("rst_busy", 32'(spi_busy), 32'd0);
    check("rst_data", 32'(spi_data_out), 32'hFF);
    check("rst_err", 32'(spi_err), 32'd0);
    check("rst_crc", 32'(spi_crc_err), 32'd0);
    rst = 0;
    idle(2);

    // Read before init, then init clears the error.
    read_block(Base, 1);
    do_init();

    // Full write of block 1 including four trailing token/CRC bytes, then read back.
    write_block(Base + 1, 516, 0);
    read_block(Base + 1, 515);

    // Data changes on the accepting edge; the later value must land in memory.
    open_session(Base + 2, 0, ok);
    if (ok) begin
      idle(2);
      spi_data_in = 8'h11;
      spi_w_byte  = 1;
      @(posedge clk);
      #1 spi_data_in = 8'hAA;
      phase(len);
      check("skew_len", 32'(len), 32'(ByteLat));
      ref_mem[2*512] = 8'hAA;
      ref_vld[2*512] = 1;
      spi_w_block = 0;
      idle(3);
    end
    read_block(Base + 2, 1);

    // Out-of-range addresses and the unsupported multi-block request.
    write_block(Base + 4, 4, 1);
    write_block(Base - 1, 4, 1);
    spi_r_multi_block = 1;
    phase(len);
    expect_err(len, "multi");
    read_block(Base + 1, 4);

    // Read and write together hold in the error state until everything drops.
    spi_block_addr = Base;
    spi_r_block = 1;
    spi_w_block = 1;
    phase(len);
    check("both_len", 32'(len), 32'd1);
    check("both_err", 32'(spi_err), 32'd1);
    count_busy(6, c);
    check("both_hold", 32'(c), 32'd0);
    spi_r_block = 0;
    count_busy(6, c);
    check("both_hold_w", 32'(c), 32'd0);
    drop_all();
    idle(3);
    do_init();

    // Randomised sessions against the model.
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) a = Base + 32'(Nb) + 32'($urandom_range(0, 1000));
        else                           a = Base - 32'd1 - 32'($urandom_range(0, 1000));
      end else begin
        a = Base + 32'($urandom_range(0, Nb - 1));
      end
      if ($urandom_range(0, 1) == 0) write_block(a, $urandom_range(1, 20), 1);
      else                           read_block(a, $urandom_range(1, 24));
      check("rand_err_flag", 32'(spi_err), 32'(ref_err));
    end

    // Reset in the middle of a byte read.
    do_init();
    open_session(Base + 1, 1, ok);
    spi_r_byte = 1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!spi_busy && t < 64);
    check("rstmid_busy_seen", 32'(spi_busy), 32'd1);
    rst = 1;
    #1;
    check("rstmid_busy", 32'(spi_busy), 32'd0);
    check("rstmid_data", 32'(spi_data_out), 32'hFF);
    check("rstmid_err", 32'(spi_err), 32'd0);
    drop_all();
    @(negedge clk);
    rst = 0;
    count_busy(4, c);
    check("rstmid_idle", 32'(c), 32'd0);
    ref_init = 0;
    ref_err  = 0;
    read_block(Base + 1, 2);
    do_init();
    read_block(Base + 1, 16);
    read_block(Base + 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
